// File: rtl/mem_arb.sv
// mem_arb: shares one single-port memory between instruction fetch and
// the LSU; one transaction at a time, data first, bounded fetch starvation.
// Ports: clk/rst; fetch req/addr -> ack/err/rdata; data req/we/be/addr/wdata
// -> ack/err/rdata; registered mem_* command, mem_rdata/mem_ready back.
module mem_arb #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic                if_err,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic                d_err,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int SW = $clog2(MAX_DATA_BURST + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_BURST);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          owner_d;
  logic          err_q;
  logic [SW-1:0] streak;
  logic [WW-1:0] wait_cnt;
  logic          grant_any;
  logic          grant_d;

  // Data wins unless fetch has already waited through a full data burst.
  always_comb begin
    grant_any = if_req | d_req;
    grant_d   = d_req & ~(if_req & (streak == STREAK_MAX));
  end

  assign mem_req = (state == S_BUSY);
  assign if_ack  = (state == S_RESP) & ~owner_d;
  assign d_ack   = (state == S_RESP) &  owner_d;
  assign if_err  = if_ack & err_q;
  assign d_err   = d_ack  & err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner_d   <= 1'b0;
      err_q     <= 1'b0;
      streak    <= '0;
      wait_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!if_req) streak <= '0;
          if (grant_any) begin
            state    <= S_BUSY;
            owner_d  <= grant_d;
            wait_cnt <= '0;
            if (grant_d) begin
              mem_we    <= d_we;
              mem_be    <= d_be;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (if_req && streak != STREAK_MAX)
                streak <= streak + 1'b1;
            end else begin
              mem_we    <= 1'b0;
              mem_be    <= '1;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              streak    <= '0;
            end
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            state <= S_RESP;
            err_q <= 1'b0;
            if (owner_d) d_rdata  <= mem_we ? '0 : mem_rdata;
            else         if_rdata <= mem_rdata;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= S_RESP;
            err_q <= 1'b1;
            if (owner_d) d_rdata  <= '0;
            else         if_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed vector table, hand sequences and a randomized run
// against a transaction-level model of the arbiter.
module tb_mem_arb;

  localparam int MB = 2;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  mem_arb #(
    .ADDR_W(32), .DATA_W(32),
    .MAX_DATA_BURST(MB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0; mem_ready = 0;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ready_at;
    int          exp_lat;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[7];

  // Starts at an IDLE cycle, returns at the IDLE cycle after the ack.
  task automatic run_txn(input vec_t v);
    bit got = 0;
    int busy = 0;
    logic [36:0] exp_cmd;
    exp_cmd = v.is_d ? {v.we, v.be, v.addr} : {1'b0, 4'hF, v.addr};
    if (v.is_d) begin
      d_req = 1; d_we = v.we; d_be = v.be;
      d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1; if_addr = v.addr;
    end
    mem_rdata = v.rdata;
    mem_ready = (v.ready_at == 1);
    for (int n = 1; n <= 20; n++) begin
      tick;
      mem_ready = (n == v.ready_at);
      if (mem_req) begin
        busy++;
        chk("cmd", {mem_we, mem_be, mem_addr}, exp_cmd);
        if (v.is_d) chk("cmd_wdata", mem_wdata, v.wdata);
      end
      if (if_ack || d_ack) begin
        got = 1;
        chk("ack_cycle", n, v.exp_lat);
        chk("ack_port", {if_ack, d_ack}, v.is_d ? 2'b01 : 2'b10);
        chk("req_in_ack", mem_req, 0);
        chk("busy_len", busy, v.exp_lat - 1);
        if (v.is_d) begin
          chk("d_err", d_err, v.exp_err);
          chk("d_rdata", d_rdata, v.exp_rdata);
        end else begin
          chk("if_err", if_err, v.exp_err);
          chk("if_rdata", if_rdata, v.exp_rdata);
        end
        break;
      end
    end
    if (!got) fail("txn_ack");
    tick;
    clear_inputs();
  endtask

  initial begin
    int order[$];
    int exp_order[6] = '{1, 1, 0, 1, 1, 0};
    bit seen;
    int streak_m, next_free, g_cyc, xfer_end, ack_cyc, k, lat;
    bit own_d, exp_err, if_rel, d_rel, in_x;
    logic [36:0] exp_cmd;
    logic [31:0] exp_wd, exp_rd, last_if, last_d;

    tbl[0] = '{0, 0, 4'hF, 32'h100,  32'h0,    32'h00500093,
               1, 2, 0, 32'h00500093};
    tbl[1] = '{1, 1, 4'h3, 32'h2004, 32'hBEEF, 32'h12345678,
               3, 4, 0, 32'h0};
    tbl[2] = '{1, 0, 4'hF, 32'h3000, 32'h0,    32'hDEADDEAD,
               0, 9, 1, 32'h0};
    tbl[3] = '{0, 0, 4'hF, 32'h104,  32'h0,    32'h00A00113,
               1, 2, 0, 32'h00A00113};
    tbl[4] = '{1, 0, 4'hC, 32'h3008, 32'h0,    32'hCAFEF00D,
               8, 9, 0, 32'hCAFEF00D};
    tbl[5] = '{0, 0, 4'hF, 32'h108,  32'h0,    32'h11111111,
               9, 9, 1, 32'h0};
    tbl[6] = '{1, 0, 4'h1, 32'h300C, 32'h0,    32'h000000AB,
               2, 3, 0, 32'h000000AB};

    // reset, with requests asserted to show reset wins
    clear_inputs();
    rst = 1; if_req = 1; d_req = 1; mem_ready = 1;
    tick; tick;
    chk("rst_ctl", {mem_req, if_ack, d_ack, if_err, d_err, mem_we, mem_be}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    rst = 0;
    clear_inputs();
    tick;

    foreach (tbl[i]) run_txn(tbl[i]);

    // contention: both keep requesting, zero-wait memory
    mem_ready = 1; if_req = 1; if_addr = 32'h1000;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h8000;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (if_ack && d_ack) chk("both_ack", 1, 0);
      if (d_ack) begin order.push_back(1); d_addr += 4; end
      if (if_ack) begin order.push_back(0); if_addr += 4; end
      if (order.size() == 6) break;
    end
    if (order.size() != 6) fail("contention");
    else for (int i = 0; i < 6; i++)
      chk($sformatf("grant_order_%0d", i), order[i], exp_order[i]);
    tick;
    clear_inputs();

    // reset in the middle of a fetch
    if_req = 1; if_addr = 32'h200; mem_rdata = 32'h5A5A5A5A;
    seen = 0;
    for (int n = 1; n <= 3; n++) begin
      tick;
      if (if_ack) seen = 1;
    end
    rst = 1;
    tick;
    chk("rstmid_req", mem_req, 0);
    chk("rstmid_cmd", {mem_we, mem_be, mem_addr}, 0);
    chk("rstmid_rdata", {if_rdata, d_rdata}, 0);
    if (if_ack) seen = 1;
    rst = 0; if_req = 0;
    tick;
    if (if_ack) seen = 1;
    if_req = 1; mem_ready = 1;
    tick;
    chk("reissue_req", mem_req, 1);
    chk("reissue_addr", mem_addr, 32'h200);
    chk("aborted_no_ack", seen, 0);
    tick;
    chk("reissue_ack", if_ack, 1);
    chk("reissue_rdata", if_rdata, 32'h5A5A5A5A);
    tick;
    clear_inputs();

    // randomized run against a transaction-level model
    rst = 1;
    tick;
    rst = 0;
    clear_inputs();
    streak_m = 0; next_free = 0;
    g_cyc = -10; xfer_end = -10; ack_cyc = -10; k = 0;
    own_d = 0; exp_err = 0; if_rel = 0; d_rel = 0;
    exp_cmd = 0; exp_wd = 0; exp_rd = 0; last_if = 0; last_d = 0;
    for (int n = 0; n < 2000; n++) begin
      if (n != 0) tick;
      if (if_rel) begin if_req = 0; if_rel = 0; end
      if (d_rel) begin d_req = 0; d_rel = 0; end
      if (!if_req && $urandom_range(0, 3) != 0) begin
        if_req = 1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && $urandom_range(0, 3) != 0) begin
        d_req = 1; d_we = 1'($urandom); d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      in_x = (n > g_cyc) && (n <= xfer_end);
      chk("rnd_mem_req", mem_req, in_x);
      if (in_x) begin
        chk("rnd_cmd", {mem_we, mem_be, mem_addr}, exp_cmd);
        if (own_d) chk("rnd_wdata", mem_wdata, exp_wd);
      end
      chk("rnd_acks", {if_ack, d_ack},
          (n == ack_cyc) ? (own_d ? 2'b01 : 2'b10) : 2'b00);
      chk("rnd_errs", {if_err, d_err},
          (n == ack_cyc && exp_err) ? (own_d ? 2'b01 : 2'b10) : 2'b00);
      if (n == ack_cyc) begin
        if (own_d) begin last_d = exp_rd; d_rel = 1; end
        else begin last_if = exp_rd; if_rel = 1; end
      end
      chk("rnd_if_rdata", if_rdata, last_if);
      chk("rnd_d_rdata", d_rdata, last_d);
      mem_rdata = $urandom;
      if (in_x) begin
        mem_ready = (n - g_cyc == k);
        if (n - g_cyc == k) exp_rd = exp_cmd[36] ? 32'h0 : mem_rdata;
      end else begin
        mem_ready = 1'($urandom);
      end
      if (n >= next_free) begin
        if (!if_req) streak_m = 0;
        if (if_req || d_req) begin
          own_d = d_req && !(if_req && streak_m == MB);
          if (own_d) begin
            if (if_req && streak_m < MB) streak_m++;
            exp_cmd = {d_we, d_be, d_addr};
            exp_wd = d_wdata;
          end else begin
            streak_m = 0;
            exp_cmd = {1'b0, 4'hF, if_addr};
          end
          k = $urandom_range(1, TO + 2);
          lat = (k > TO) ? TO : k;
          exp_err = (k > TO);
          exp_rd = 0;
          g_cyc = n;
          xfer_end = n + lat;
          ack_cyc = n + lat + 1;
          next_free = n + lat + 2;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port arbiter that shares the core's single-port memory between instruction fetch and data load/store. It sits between the fetch stage and LSU on one side and the memory interface on the other. It sequences one transaction at a time through a small FSM. Data has priority, with a bounded-starvation guard for fetch and a wait-state timeout that reports a bus error.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; byte enables are DATA_W/8 wide
- MAX_DATA_BURST, 4, consecutive data grants allowed while fetch waits (≥1)
- TIMEOUT, 16, max BUSY cycles without mem_ready before abort (≥2)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_ack  out  1  one-cycle completion pulse to fetch
- if_err  out  1  valid with if_ack: transfer timed out
- if_rdata  out  DATA_W  fetched word, valid with if_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle completion pulse to LSU
- d_err  out  1  valid with d_ack: transfer timed out
- d_rdata  out  DATA_W  load data, valid with d_ack; 0 for stores
- mem_req  out  1  memory transaction active
- mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  registered command
- mem_rdata  in  DATA_W  read data, sampled in the mem_ready cycle
- mem_ready  in  1  transfer completes in this cycle

## Operation
- FSM states: IDLE, BUSY, RESP. The owner register (IF/D) is set on grant.
- IDLE: if any request is pending, pick a winner, register its command into mem_*, and go to BUSY. Otherwise stay.
- Arbitration:
  - Only d_req: grant D.
  - Only if_req: grant IF.
  - Both requesting: grant D unless streak == MAX_DATA_BURST, then grant IF.
- Streak counter:
  - Increments on each D grant made while if_req = 1.
  - Clears on any IF grant, and in any IDLE cycle with if_req = 0.
  - Saturates at MAX_DATA_BURST.
- Fetch command: mem_we = 0, mem_be = all ones.
- BUSY: mem_req = 1 and mem_* are held stable.
  - On mem_ready: capture mem_rdata (forced to 0 for stores), clear err, go to RESP.
  - Wait counter increments each BUSY cycle without mem_ready.
  - If the TIMEOUT-th BUSY cycle has no mem_ready: capture rdata = 0, set err = 1, go to RESP.
- RESP: mem_req = 0. Assert the owner's ack and err, with rdata from the capture register. Go to IDLE.
- Requester protocol: deassert req the cycle after ack. A new request may be raised from that cycle onward.
- Non-owner ack/err are 0. if_rdata and d_rdata hold their last captured value outside ack.

## Timing
- Reset values: state IDLE; mem_req, if_ack, d_ack, if_err, d_err = 0; mem_we, mem_be, mem_addr, mem_wdata = 0; if_rdata, d_rdata = 0; streak and wait counters = 0.
- Request seen in IDLE at cycle t: mem_req is high from t+1.
- mem_ready at cycle t+k (k ≥ 1): ack at t+k+1, IDLE at t+k+2.
- Minimum latency from req to ack is 2 cycles. Peak throughput is one transaction per 3 cycles.
- mem_ready is ignored outside BUSY.
- A request arriving in BUSY or RESP waits. It is arbitrated in the next IDLE cycle.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then ack with err follows in the next cycle.
- mem_ready on the TIMEOUT-th cycle counts as success (err = 0).
- Reset mid-BUSY or mid-RESP: the next cycle is IDLE with all outputs at reset values. No ack is issued for the aborted transfer; the requester must reissue it.
- Reset overrides all other inputs in the same cycle.

## Test plan
- Single fetch, zero-wait: set mem_ready = 1, mem_rdata = 0x00500093, if_req at c0 with addr 0x100. Required: mem_req = 1 at c1 with mem_addr = 0x100, we = 0, be = 0xF; if_ack = 1 at c2 with if_rdata = 0x00500093 and if_err = 0; mem_req = 0 at c2.
- Store with 2 wait states: d_req at c0 with d_we = 1, be = 0x3, addr 0x2004, wdata 0xBEEF; mem_ready only at c3. Required: mem_* stable over c1–c3; d_ack at c4 with d_rdata = 0 and d_err = 0.
- Contention, MAX_DATA_BURST = 2, both requesting continuously (each re-raises req after ack), zero-wait memory. Required: grant order D, D, IF, D, D, IF; no two consecutive if_ack while d_req is pending.
- Timeout, TIMEOUT = 8, mem_ready tied 0, d_req at c0 (load). Required: mem_req = 1 at c1–c8; d_ack = 1 and d_err = 1 at c9 with d_rdata = 0. A follow-up fetch with mem_ready = 1 then completes with if_err = 0.
- Ready on the last allowed cycle, TIMEOUT = 8: mem_ready at c8 only. Required: ack at c9 with err = 0.
- Reset mid-BUSY: if_req at c0, mem_ready = 0, rst at c3. Required: at c4 mem_req = 0, no if_ack ever issued, streak = 0. The reissued if_req at c5 gets mem_req at c6.
